reorder_buffer: RTL and testbench

//  Circular reorder buffer at the commit end of the rename/commit protocol that the register file consumes.

---
 rtl/reorder_buffer_if.sv | 52 +++++
 rtl/reorder_buffer.sv | 143 ++++++++++++++
 tb/tb_reorder_buffer.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_if.sv
// Decoder/CDB/register-file side signals of the reorder buffer.
interface reorder_buffer_if #(
    parameter int unsigned TAG_W  = 4,
    parameter int unsigned REG_W  = 5,
    parameter int unsigned DATA_W = 32
);
    logic              in_alloc_valid;
    logic [REG_W-1:0]  in_alloc_reg;
    logic              in_alloc_branch;
    logic              in_alloc_pred;
    logic [TAG_W-1:0]  out_alloc_tag;
    logic              out_full;

    logic [TAG_W-1:0]  in_query_tag1;
    logic [TAG_W-1:0]  in_query_tag2;
    logic              out_query_rdy1;
    logic              out_query_rdy2;
    logic [DATA_W-1:0] out_query_val1;
    logic [DATA_W-1:0] out_query_val2;

    logic              in_cdb_valid;
    logic [TAG_W-1:0]  in_cdb_tag;
    logic [DATA_W-1:0] in_cdb_value;
    logic              in_cdb_taken;
    logic [DATA_W-1:0] in_cdb_target;

    logic [REG_W-1:0]  out_commit_reg;
    logic [TAG_W-1:0]  out_commit_tag;
    logic [DATA_W-1:0] out_commit_value;
    logic              out_misbranch;
    logic [DATA_W-1:0] out_redirect_pc;

    modport master (
        output in_alloc_valid, in_alloc_reg, in_alloc_branch, in_alloc_pred,
        output in_query_tag1, in_query_tag2,
        output in_cdb_valid, in_cdb_tag, in_cdb_value, in_cdb_taken, in_cdb_target,
        input  out_alloc_tag, out_full,
        input  out_query_rdy1, out_query_rdy2, out_query_val1, out_query_val2,
        input  out_commit_reg, out_commit_tag, out_commit_value,
        input  out_misbranch, out_redirect_pc
    );

    modport slave (
        input  in_alloc_valid, in_alloc_reg, in_alloc_branch, in_alloc_pred,
        input  in_query_tag1, in_query_tag2,
        input  in_cdb_valid, in_cdb_tag, in_cdb_value, in_cdb_taken, in_cdb_target,
        output out_alloc_tag, out_full,
        output out_query_rdy1, out_query_rdy2, out_query_val1, out_query_val2,
        output out_commit_reg, out_commit_tag, out_commit_value,
        output out_misbranch, out_redirect_pc
    );
endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocate, out-of-order CDB writeback,
// in-order single commit per cycle with branch-mispredict flush.
module reorder_buffer #(
    parameter int unsigned DEPTH  = 15,
    parameter int unsigned TAG_W  = 4,
    parameter int unsigned REG_W  = 5,
    parameter int unsigned DATA_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    reorder_buffer_if.slave  bus
);
    // Storage covers every tag value; tag 0 and tags above DEPTH are never written.
    localparam int unsigned SLOTS = 2 ** TAG_W;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic              busy;
        logic              ready;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] value;
        logic              branch;
        logic              pred;
        logic              taken;
        logic [DATA_W-1:0] target;
    } entry_t;

    entry_t            rob_q [SLOTS];
    entry_t            rob_d [SLOTS];
    logic [TAG_W-1:0]  head_q, head_d;
    logic [TAG_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q, full_d;
    logic [REG_W-1:0]  commit_reg_q, commit_reg_d;
    logic [TAG_W-1:0]  commit_tag_q, commit_tag_d;
    logic [DATA_W-1:0] commit_value_q, commit_value_d;
    logic              misbranch_q, misbranch_d;
    logic [DATA_W-1:0] redirect_q, redirect_d;

    entry_t head_e;
    logic   commit_c, mis_c, alloc_c, wb_c;

    function automatic logic [TAG_W-1:0] next_ptr(input logic [TAG_W-1:0] p);
        return (p == TAG_W'(DEPTH)) ? TAG_W'(1) : p + TAG_W'(1);
    endfunction

    // Next-state: writeback, then commit clear, then allocation; a flush overrides all.
    always_comb begin
        rob_d          = rob_q;
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        full_d         = full_q;

        head_e   = rob_q[head_q];
        commit_c = head_e.busy & head_e.ready;
        mis_c    = commit_c & head_e.branch & (head_e.taken != head_e.pred);
        alloc_c  = bus.in_alloc_valid & ~full_q;
        wb_c     = bus.in_cdb_valid & (bus.in_cdb_tag != '0) & rob_q[bus.in_cdb_tag].busy;

        commit_reg_d   = (commit_c & ~head_e.branch) ? head_e.rd : '0;
        commit_tag_d   = commit_c ? head_q : '0;
        commit_value_d = commit_c ? head_e.value : '0;
        misbranch_d    = mis_c;
        redirect_d     = mis_c ? head_e.target : '0;

        if (mis_c) begin
            for (int i = 0; i < int'(SLOTS); i++) rob_d[i] = '0;
            head_d  = TAG_W'(1);
            tail_d  = TAG_W'(1);
            count_d = '0;
            full_d  = 1'b0;
        end else begin
            if (wb_c) begin
                rob_d[bus.in_cdb_tag].ready  = 1'b1;
                rob_d[bus.in_cdb_tag].value  = bus.in_cdb_value;
                rob_d[bus.in_cdb_tag].taken  = bus.in_cdb_taken;
                rob_d[bus.in_cdb_tag].target = bus.in_cdb_target;
            end
            if (commit_c) begin
                rob_d[head_q] = '0;
                head_d        = next_ptr(head_q);
            end
            if (alloc_c) begin
                rob_d[tail_q] = '{busy:   1'b1,
                                  ready:  1'b0,
                                  rd:     bus.in_alloc_reg,
                                  value:  '0,
                                  branch: bus.in_alloc_branch,
                                  pred:   bus.in_alloc_pred,
                                  taken:  1'b0,
                                  target: '0};
                tail_d = next_ptr(tail_q);
            end
            count_d = count_q + CNT_W'(alloc_c) - CNT_W'(commit_c);
            full_d  = (count_d == CNT_W'(DEPTH));
        end
    end

    // rdy acts as a clock enable for every register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(SLOTS); i++) rob_q[i] <= '0;
            head_q         <= TAG_W'(1);
            tail_q         <= TAG_W'(1);
            count_q        <= '0;
            full_q         <= 1'b0;
            commit_reg_q   <= '0;
            commit_tag_q   <= '0;
            commit_value_q <= '0;
            misbranch_q    <= 1'b0;
            redirect_q     <= '0;
        end else if (rdy) begin
            for (int i = 0; i < int'(SLOTS); i++) rob_q[i] <= rob_d[i];
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            full_q         <= full_d;
            commit_reg_q   <= commit_reg_d;
            commit_tag_q   <= commit_tag_d;
            commit_value_q <= commit_value_d;
            misbranch_q    <= misbranch_d;
            redirect_q     <= redirect_d;
        end
    end

    assign bus.out_alloc_tag    = tail_q;
    assign bus.out_full         = full_q;
    assign bus.out_commit_reg   = commit_reg_q;
    assign bus.out_commit_tag   = commit_tag_q;
    assign bus.out_commit_value = commit_value_q;
    assign bus.out_misbranch    = misbranch_q;
    assign bus.out_redirect_pc  = redirect_q;

    // Forwarding lookups see registered state only; tag 0 never matches.
    assign bus.out_query_rdy1 = (bus.in_query_tag1 != '0) &
                                rob_q[bus.in_query_tag1].busy & rob_q[bus.in_query_tag1].ready;
    assign bus.out_query_rdy2 = (bus.in_query_tag2 != '0) &
                                rob_q[bus.in_query_tag2].busy & rob_q[bus.in_query_tag2].ready;
    assign bus.out_query_val1 = (bus.in_query_tag1 != '0) ? rob_q[bus.in_query_tag1].value : '0;
    assign bus.out_query_val2 = (bus.in_query_tag2 != '0) ? rob_q[bus.in_query_tag2].value : '0;
endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: vector table plus hand-written corner sequences,
// commits checked against an in-order expectation queue.
module tb_reorder_buffer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rdy = 1'b1;

    always #5 clk = ~clk;

    reorder_buffer_if #(.TAG_W(4), .REG_W(5), .DATA_W(32)) bus ();

    reorder_buffer #(.DEPTH(15), .TAG_W(4), .REG_W(5), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [3:0]  tag;
        logic [31:0] val;
    } exp_t;

    typedef struct {
        logic        av;
        logic [4:0]  ar;
        logic        cv;
        logic [3:0]  ct;
        logic [31:0] cval;
        logic [3:0]  q1;
        logic [3:0]  q2;
        logic        push;
        exp_t        pe;
        logic [3:0]  e_tag;
        logic        e_full;
        logic        e_r1;
        logic [31:0] e_v1;
        logic        e_r2;
        logic [31:0] e_v2;
    } vec_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_idle();
        bus.in_alloc_valid  = 1'b0;
        bus.in_alloc_reg    = '0;
        bus.in_alloc_branch = 1'b0;
        bus.in_alloc_pred   = 1'b0;
        bus.in_cdb_valid    = 1'b0;
        bus.in_cdb_tag      = '0;
        bus.in_cdb_value    = '0;
        bus.in_cdb_taken    = 1'b0;
        bus.in_cdb_target   = '0;
        bus.in_query_tag1   = '0;
        bus.in_query_tag2   = '0;
    endtask

    task automatic alloc(input logic [4:0] r, input logic br, input logic pr);
        bus.in_alloc_valid  = 1'b1;
        bus.in_alloc_reg    = r;
        bus.in_alloc_branch = br;
        bus.in_alloc_pred   = pr;
    endtask

    task automatic cdb(input logic [3:0] t, input logic [31:0] v, input logic tk,
                       input logic [31:0] tg);
        bus.in_cdb_valid  = 1'b1;
        bus.in_cdb_tag    = t;
        bus.in_cdb_value  = v;
        bus.in_cdb_taken  = tk;
        bus.in_cdb_target = tg;
    endtask

    // Asserted at a negedge; checks the asynchronous clear before any clock edge.
    task automatic apply_reset(input string tag);
        rst = 1'b0;
        set_idle();
        #1;
        chk({tag, "_alloc_tag"}, 32'(bus.out_alloc_tag), 32'd1);
        chk({tag, "_full"}, 32'(bus.out_full), 32'd0);
        chk({tag, "_commit_reg"}, 32'(bus.out_commit_reg), 32'd0);
        chk({tag, "_commit_tag"}, 32'(bus.out_commit_tag), 32'd0);
        chk({tag, "_misbranch"}, 32'(bus.out_misbranch), 32'd0);
        chk({tag, "_redirect"}, bus.out_redirect_pc, 32'd0);
        #1;
        rst = 1'b1;
    endtask

    function automatic vec_t mk(input logic av, input logic [4:0] ar, input logic cv,
                                input logic [3:0] ct, input logic [31:0] cval,
                                input logic [3:0] q1, input logic [3:0] q2,
                                input logic push, input logic [4:0] prd,
                                input logic [3:0] ptag, input logic [31:0] pval,
                                input logic [3:0] e_tag, input logic e_full,
                                input logic e_r1, input logic [31:0] e_v1,
                                input logic e_r2, input logic [31:0] e_v2);
        vec_t v;
        v.av = av; v.ar = ar; v.cv = cv; v.ct = ct; v.cval = cval;
        v.q1 = q1; v.q2 = q2; v.push = push;
        v.pe = '{rd: prd, tag: ptag, val: pval};
        v.e_tag = e_tag; v.e_full = e_full;
        v.e_r1 = e_r1; v.e_v1 = e_v1; v.e_r2 = e_r2; v.e_v2 = e_v2;
        return v;
    endfunction

    // Commit monitor: any commit pulse after an enabled edge must match the queue head.
    initial begin
        logic en;
        exp_t e;
        forever begin
            @(posedge clk);
            en = rdy && rst;
            @(negedge clk);
            if (en && bus.out_commit_tag != '0) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL commit_unexpected: got tag %0d reg %0d with nothing expected",
                             bus.out_commit_tag, bus.out_commit_reg);
                end else begin
                    e = sb.pop_front();
                    chk("commit_reg", 32'(bus.out_commit_reg), 32'(e.rd));
                    chk("commit_tag", 32'(bus.out_commit_tag), 32'(e.tag));
                    chk("commit_value", bus.out_commit_value, e.val);
                end
            end
        end
    end

    vec_t tbl[13];

    initial begin
        // Basic commit, out-of-order writeback, query and ignored writebacks.
        tbl[0]  = mk(1, 5, 0, 0, 0,            1, 0, 0, 0, 0, 0,        2, 0, 0, 0,      0, 0);
        tbl[1]  = mk(0, 0, 1, 1, 32'h1234,     1, 2, 1, 5, 1, 32'h1234, 2, 0, 1, 32'h1234, 0, 0);
        tbl[2]  = mk(0, 0, 0, 0, 0,            1, 0, 0, 0, 0, 0,        2, 0, 0, 0,      0, 0);
        tbl[3]  = mk(0, 0, 0, 0, 0,            1, 0, 0, 0, 0, 0,        2, 0, 0, 0,      0, 0);
        tbl[4]  = mk(1, 1, 0, 0, 0,            2, 3, 0, 0, 0, 0,        3, 0, 0, 0,      0, 0);
        tbl[5]  = mk(1, 2, 0, 0, 0,            3, 2, 0, 0, 0, 0,        4, 0, 0, 0,      0, 0);
        tbl[6]  = mk(0, 0, 1, 3, 7,            3, 2, 0, 0, 0, 0,        4, 0, 1, 7,      0, 0);
        tbl[7]  = mk(0, 0, 0, 0, 0,            3, 3, 0, 0, 0, 0,        4, 0, 1, 7,      1, 7);
        tbl[8]  = mk(0, 0, 1, 2, 3,            2, 3, 1, 1, 2, 3,        4, 0, 1, 3,      1, 7);
        tbl[9]  = mk(0, 0, 0, 0, 0,            2, 3, 1, 2, 3, 7,        4, 0, 0, 0,      1, 7);
        tbl[10] = mk(0, 0, 0, 0, 0,            3, 2, 0, 0, 0, 0,        4, 0, 0, 0,      0, 0);
        tbl[11] = mk(0, 0, 1, 5, 32'hdead,     5, 0, 0, 0, 0, 0,        4, 0, 0, 0,      0, 0);
        tbl[12] = mk(0, 0, 1, 0, 32'h55,       0, 4, 0, 0, 0, 0,        4, 0, 0, 0,      0, 0);

        set_idle();
        @(negedge clk);
        apply_reset("rst0");
        tick();
        chk("init_alloc_tag", 32'(bus.out_alloc_tag), 32'd1);
        chk("init_full", 32'(bus.out_full), 32'd0);
        chk("init_commit_reg", 32'(bus.out_commit_reg), 32'd0);
        chk("init_misbranch", 32'(bus.out_misbranch), 32'd0);

        for (int i = 0; i < 13; i++) begin
            bus.in_alloc_valid  = tbl[i].av;
            bus.in_alloc_reg    = tbl[i].ar;
            bus.in_alloc_branch = 1'b0;
            bus.in_alloc_pred   = 1'b0;
            bus.in_cdb_valid    = tbl[i].cv;
            bus.in_cdb_tag      = tbl[i].ct;
            bus.in_cdb_value    = tbl[i].cval;
            bus.in_cdb_taken    = 1'b0;
            bus.in_cdb_target   = '0;
            bus.in_query_tag1   = tbl[i].q1;
            bus.in_query_tag2   = tbl[i].q2;
            if (tbl[i].push) sb.push_back(tbl[i].pe);
            tick();
            chk($sformatf("v%0d_alloc_tag", i), 32'(bus.out_alloc_tag), 32'(tbl[i].e_tag));
            chk($sformatf("v%0d_full", i), 32'(bus.out_full), 32'(tbl[i].e_full));
            chk($sformatf("v%0d_q_rdy1", i), 32'(bus.out_query_rdy1), 32'(tbl[i].e_r1));
            chk($sformatf("v%0d_q_val1", i), bus.out_query_val1, tbl[i].e_v1);
            chk($sformatf("v%0d_q_rdy2", i), 32'(bus.out_query_rdy2), 32'(tbl[i].e_r2));
            chk($sformatf("v%0d_q_val2", i), bus.out_query_val2, tbl[i].e_v2);
        end
        set_idle();

        // Fill to DEPTH, overflow allocation, full blocking across a commit.
        apply_reset("rst1");
        for (int i = 0; i < 15; i++) begin
            alloc(5'(i + 1), 1'b0, 1'b0);
            tick();
        end
        chk("fill_full", 32'(bus.out_full), 32'd1);
        chk("fill_alloc_tag", 32'(bus.out_alloc_tag), 32'd1);
        alloc(5'd31, 1'b0, 1'b0);
        tick();
        chk("ovf_full", 32'(bus.out_full), 32'd1);
        chk("ovf_alloc_tag", 32'(bus.out_alloc_tag), 32'd1);
        set_idle();
        cdb(4'd1, 32'ha1, 1'b0, 32'd0);
        sb.push_back('{rd: 5'd1, tag: 4'd1, val: 32'ha1});
        tick();
        chk("wb_full", 32'(bus.out_full), 32'd1);
        set_idle();
        alloc(5'd9, 1'b0, 1'b0);
        tick();
        chk("cmt_full", 32'(bus.out_full), 32'd0);
        chk("cmt_alloc_tag", 32'(bus.out_alloc_tag), 32'd1);
        tick();
        chk("refill_alloc_tag", 32'(bus.out_alloc_tag), 32'd2);
        chk("refill_full", 32'(bus.out_full), 32'd1);
        set_idle();

        // Reset while full: entries discarded asynchronously.
        apply_reset("rst2");
        bus.in_query_tag1 = 4'd5;
        tick();
        chk("rst2_q_rdy1", 32'(bus.out_query_rdy1), 32'd0);

        // Mispredicted branch at head flushes; same-cycle alloc/CDB dropped.
        alloc(5'd0, 1'b1, 1'b0);
        tick();
        alloc(5'd3, 1'b0, 1'b0);
        tick();
        set_idle();
        cdb(4'd1, 32'd0, 1'b1, 32'h100);
        sb.push_back('{rd: 5'd0, tag: 4'd1, val: 32'd0});
        tick();
        chk("mis_pre_misbranch", 32'(bus.out_misbranch), 32'd0);
        cdb(4'd2, 32'd9, 1'b0, 32'd0);
        alloc(5'd4, 1'b0, 1'b0);
        bus.in_query_tag2 = 4'd2;
        tick();
        chk("mis_misbranch", 32'(bus.out_misbranch), 32'd1);
        chk("mis_redirect", bus.out_redirect_pc, 32'h100);
        chk("mis_commit_reg", 32'(bus.out_commit_reg), 32'd0);
        chk("mis_alloc_tag", 32'(bus.out_alloc_tag), 32'd1);
        chk("mis_full", 32'(bus.out_full), 32'd0);
        chk("mis_q_rdy2", 32'(bus.out_query_rdy2), 32'd0);
        set_idle();
        cdb(4'd2, 32'd9, 1'b0, 32'd0);
        bus.in_query_tag2 = 4'd2;
        tick();
        chk("late_misbranch", 32'(bus.out_misbranch), 32'd0);
        chk("late_redirect", bus.out_redirect_pc, 32'd0);
        chk("late_q_rdy2", 32'(bus.out_query_rdy2), 32'd0);
        chk("late_q_val2", bus.out_query_val2, 32'd0);
        chk("late_alloc_tag", 32'(bus.out_alloc_tag), 32'd1);

        // Correctly predicted branch commits without a flush.
        set_idle();
        alloc(5'd0, 1'b1, 1'b1);
        tick();
        set_idle();
        cdb(4'd1, 32'd0, 1'b1, 32'h200);
        sb.push_back('{rd: 5'd0, tag: 4'd1, val: 32'd0});
        tick();
        set_idle();
        tick();
        chk("okbr_misbranch", 32'(bus.out_misbranch), 32'd0);
        chk("okbr_redirect", bus.out_redirect_pc, 32'd0);
        chk("okbr_commit_reg", 32'(bus.out_commit_reg), 32'd0);
        chk("okbr_alloc_tag", 32'(bus.out_alloc_tag), 32'd2);

        // rdy=0 freezes state and holds commit outputs.
        apply_reset("rst3");
        alloc(5'd7, 1'b0, 1'b0);
        tick();
        set_idle();
        cdb(4'd1, 32'hbeef, 1'b0, 32'd0);
        sb.push_back('{rd: 5'd7, tag: 4'd1, val: 32'hbeef});
        tick();
        set_idle();
        rdy = 1'b0;
        alloc(5'd8, 1'b0, 1'b0);
        bus.in_query_tag1 = 4'd1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("frz%0d_commit_tag", i), 32'(bus.out_commit_tag), 32'd0);
            chk($sformatf("frz%0d_alloc_tag", i), 32'(bus.out_alloc_tag), 32'd2);
            chk($sformatf("frz%0d_q_rdy1", i), 32'(bus.out_query_rdy1), 32'd1);
            chk($sformatf("frz%0d_q_val1", i), bus.out_query_val1, 32'hbeef);
        end
        rdy = 1'b1;
        bus.in_alloc_valid = 1'b0;
        tick();
        chk("thaw_commit_reg", 32'(bus.out_commit_reg), 32'd7);
        chk("thaw_alloc_tag", 32'(bus.out_alloc_tag), 32'd2);
        rdy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk($sformatf("hold%0d_commit_reg", i), 32'(bus.out_commit_reg), 32'd7);
            chk($sformatf("hold%0d_commit_tag", i), 32'(bus.out_commit_tag), 32'd1);
            chk($sformatf("hold%0d_commit_val", i), bus.out_commit_value, 32'hbeef);
        end
        rdy = 1'b1;
        tick();
        chk("pulse_commit_reg", 32'(bus.out_commit_reg), 32'd0);
        chk("pulse_commit_tag", 32'(bus.out_commit_tag), 32'd0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
